tick_divider_bank: RTL and testbench
====================================

// Module: tick_divider_bank
// PURPOSE
//  Parametrised multi-channel tick generator for the stopwatch datapath. It divides the single system clock into NUM_CH independent channels.
//  Each channel has a runtime-loadable divisor, individual pause and clear inputs, a one-cycle tick pulse and a 50%-duty square output.
//  A separate base prescaler free-runs for display multiplexing and is never paused.
//  It feeds the BCD time counters (tick) and the 7-seg scan logic (base_tick).
// PARAMETERS
//  NUM_CH    4                        number of divider channels (>=1)
//  CNT_W     27                       counter/divisor width, bits
//  DEF_DIV   {4{27'd50_000_000}}      packed NUM_CH*CNT_W reset divisors; ch i = DEF_DIV[i*CNT_W +: CNT_W]
//  BASE_DIV  200_000                  base prescaler period in clk cycles (>=1)
//  CH_W      localparam max(1,$clog2(NUM_CH))
// PORTS
//  clk        in   1               system clock (100 MHz), sole clock
//  rst        in   1               synchronous, active-low reset
//  pause      in   NUM_CH          per-channel hold; bit i freezes channel i
//  clr        in   NUM_CH          per-channel clear; bit i zeroes channel i
//  cfg_wr     in   1               one-cycle divisor write strobe
//  cfg_ch     in   CH_W            channel addressed by cfg_wr
//  cfg_div    in   CNT_W           new divisor N (period in clk cycles)
//  tick       out  NUM_CH          registered 1-cycle pulse every N active cycles
//  sq         out  NUM_CH          toggles on every tick of that channel
//  base_tick  out  1               registered 1-cycle pulse every BASE_DIV cycles
// BEHAVIOUR
//  - All state is updated on posedge clk only. No combinational path runs from any input to any output.
//  - Reset (rst==0): every cnt=0, tick=0, sq=0, div[i]=DEF_DIV slice, base cnt=0, base_tick=0. Reset wins over all other inputs.
//  - Per-channel priority, evaluated each cycle: reset > cfg write to this channel > clr[i] > (pause[i] | div==0) > count.
//  - cfg write (cfg_wr & cfg_ch==i): div[i]<=cfg_div, cnt<=0, tick<=0, sq holds. Counting under the new divisor starts on the next cycle.
//    If cfg_ch>=NUM_CH, the write is ignored with no side effects.
//  - clr[i]: cnt<=0, tick<=0, sq<=0. Clear takes effect even while paused.
//  - Hold (pause[i]=1 or div==0): cnt holds and sq holds; tick<=0 every held cycle.
//    Releasing pause resumes from the held count, so the remaining period is preserved.
//  - Count: if cnt==div-1 then cnt<=0, tick<=1, sq<=~sq. Otherwise cnt<=cnt+1 and tick<=0.
//  - Latency: after rst rises or after a clr/cfg write (cycle 0), the first tick is high in active cycle N.
//    Every N active cycles after that, tick is high for exactly 1 cycle.
//  - N=1: tick stays high every active cycle and sq toggles every cycle. N=2^CNT_W-1 is legal.
//    cnt never exceeds div-1, so it never wraps past the divisor.
//  - base prescaler: base_cnt runs 0..BASE_DIV-1 and base_tick=1 on wrap. It ignores pause, clr and cfg; only rst affects it.
//  - Channels are fully independent. Simultaneous clr/pause/cfg on different channels each apply the rule above to their own channel.
// STRUCTURE
//  - Package tick_pkg holds: CLK_HZ=100_000_000; DIV_1HZ=100_000_000; DIV_2HZ=50_000_000; DIV_500HZ=200_000; default CNT_W=27.
//  - Sub-module tick_channel: one cnt/div/tick/sq slice with inputs pause, clr, ld, ld_div and parameter RST_DIV.
//    The top instantiates it NUM_CH times in a generate loop, with ld = cfg_wr & (cfg_ch==i).
//  - The base prescaler is inline in the top as a fixed-divisor counter.
// TESTING (bench overrides NUM_CH=2, CNT_W=8, DEF_DIV={8'd3,8'd5}, BASE_DIV=4)
//  1 Release rst, no other stimulus. Expect: ch0 tick in cycles 5,10,15; ch1 tick in 3,6,9; sq0 0->1->0 at each ch0 tick; base_tick at 4,8.
//  2 Hold pause[0] for 2 cycles starting at cnt0==2. Expect: ch0 tick slips exactly 2 cycles (from 5 to 7); ch1 and base_tick unaffected.
//  3 Assert clr[0] while pause[0]=1 at cnt0==3. Expect: cnt0=0 and sq0=0. After pause drops, the next tick comes 5 active cycles later.
//  4 Write cfg_wr, cfg_ch=0, cfg_div=1. Expect: tick0 high every cycle from the 2nd cycle on. Then cfg_div=0: tick0 stays 0 and sq0 frozen.
//  5 Write cfg_wr, cfg_ch=3 (out of range). Expect: no change to any div, cnt, tick or sq.
//    Also assert clr[1] and cfg to ch1 in the same cycle: cfg wins, div1 is updated and sq1 is held.
//  6 Pull rst low for 1 cycle mid-count with all channels running. Expect: all outputs 0 next cycle and divisors back to {3,5}.
//    Then repeat the scenario 1 timing exactly.

Source files
------------

// File: rtl/tick_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tick_pkg                                                    |
// | Desc   : Shared clock-rate and divisor constants for the tick bank.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package tick_pkg;
  localparam int unsigned CLK_HZ     = 100_000_000;
  localparam int unsigned DIV_1HZ    = 100_000_000;
  localparam int unsigned DIV_2HZ    = 50_000_000;
  localparam int unsigned DIV_500HZ  = 200_000;
  localparam int unsigned DEF_CNT_W  = 27;
endpackage
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tick_channel                                                |
// | Desc   : One divider slice: loadable divisor, pause, clear, tick, sq |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned          CNT_W   = DEF_CNT_W,
  parameter logic [CNT_W-1:0]     RST_DIV = CNT_W'(DIV_1HZ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_tick;
  logic             r_sq;

  // Zero divisor is treated as a hold, so div-1 is only evaluated when div>=1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_div  <= RST_DIV;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (ld) begin
      r_div  <= ld_div;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else if (pause || (r_div == '0)) begin
      r_tick <= 1'b0;
    end else if (r_cnt == (r_div - CNT_W'(1))) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_sq   <= ~r_sq;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;
  assign sq   = r_sq;

endmodule
`default_nettype wire

// File: rtl/tick_divider_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tick_divider_bank                                           |
// | Desc   : NUM_CH independent tick dividers plus a free-running base   |
// |          prescaler for display multiplexing.                         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int unsigned                NUM_CH   = 4,
  parameter int unsigned                CNT_W    = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]    DEF_DIV  = {NUM_CH{CNT_W'(DIV_2HZ)}},
  parameter int unsigned                BASE_DIV = DIV_500HZ,
  localparam int unsigned               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pause,
  input  logic [NUM_CH-1:0] clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq,
  output logic              base_tick
);

  localparam int unsigned BASE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;

  logic [NUM_CH-1:0] w_ld;
  logic [BASE_W-1:0] r_base_cnt;
  logic              r_base_tick;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Addresses at or beyond NUM_CH match no slice, so such writes vanish.
    assign w_ld[i] = cfg_wr && (32'(cfg_ch) == i);

    tick_channel #(
      .CNT_W   (CNT_W),
      .RST_DIV (DEF_DIV[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .pause  (pause[i]),
      .clr    (clr[i]),
      .ld     (w_ld[i]),
      .ld_div (cfg_div),
      .tick   (tick[i]),
      .sq     (sq[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_base_cnt  <= '0;
      r_base_tick <= 1'b0;
    end else if (r_base_cnt == BASE_W'(BASE_DIV - 1)) begin
      r_base_cnt  <= '0;
      r_base_tick <= 1'b1;
    end else begin
      r_base_cnt  <= r_base_cnt + BASE_W'(1);
      r_base_tick <= 1'b0;
    end
  end

  assign base_tick = r_base_tick;

endmodule
`default_nettype wire

// File: tb/tb_tick_divider_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_tick_divider_bank                                        |
// | Desc   : Scoreboard bench for tick_divider_bank (2-ch and 3-ch).     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_tick_divider_bank;

  typedef struct packed {
    logic [1:0] tick;
    logic [1:0] sq;
    logic       base;
  } exp_t;

  typedef struct packed {
    logic [2:0] tick;
    logic [2:0] sq;
    logic       base;
  } exp3_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] pause = '0;
  logic [1:0] clr = '0;
  logic       cfg_wr = 1'b0;
  logic       cfg_ch = 1'b0;
  logic [7:0] cfg_div = '0;
  logic [1:0] tick;
  logic [1:0] sq;
  logic       base_tick;

  logic [2:0] pause2 = '0;
  logic [2:0] clr2 = '0;
  logic       cfg_wr2 = 1'b0;
  logic [1:0] cfg_ch2 = '0;
  logic [7:0] cfg_div2 = '0;
  logic [2:0] tick2;
  logic [2:0] sq2;
  logic       base_tick2;

  exp_t  sb[$];
  exp3_t sb3[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  tick_divider_bank #(
    .NUM_CH(2), .CNT_W(8), .DEF_DIV({8'd3, 8'd5}), .BASE_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause), .clr(clr),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .tick(tick), .sq(sq), .base_tick(base_tick)
  );

  // Three channels give a 2-bit address, so an out-of-range write is expressible.
  tick_divider_bank #(
    .NUM_CH(3), .CNT_W(8), .DEF_DIV({8'd4, 8'd3, 8'd5}), .BASE_DIV(4)
  ) dut3 (
    .clk(clk), .rst(rst), .pause(pause2), .clr(clr2),
    .cfg_wr(cfg_wr2), .cfg_ch(cfg_ch2), .cfg_div(cfg_div2),
    .tick(tick2), .sq(sq2), .base_tick(base_tick2)
  );

  task automatic do_reset();
    rst = 1'b0; pause = '0; clr = '0; cfg_wr = 1'b0; cfg_wr2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    do_reset();
    sb.push_back('0);
    got = {tick, sq, base_tick};
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=%b", got, e);
    end
  endtask

  task automatic test_free_run(string tag);
    exp_t e, got;
    for (int c = 1; c <= 16; c++) begin
      e.tick[0] = (c % 5 == 0);
      e.tick[1] = (c % 3 == 0);
      e.sq[0]   = ((c / 5) % 2 == 1);
      e.sq[1]   = ((c / 3) % 2 == 1);
      e.base    = (c % 4 == 0);
      sb.push_back(e);
      @(posedge clk); #1;
      got = {tick, sq, base_tick};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s c=%0d got tick=%b sq=%b base=%b exp tick=%b sq=%b base=%b",
                 tag, c, got.tick, got.sq, got.base, e.tick, e.sq, e.base);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e, got;
    int a;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      pause = {1'b0, (c == 3 || c == 4)};
      a = (c < 3) ? c : ((c < 5) ? 2 : c - 2);
      e.tick[0] = (a % 5 == 0) && !(c == 3 || c == 4);
      e.tick[1] = (c % 3 == 0);
      e.sq[0]   = ((a / 5) % 2 == 1);
      e.sq[1]   = ((c / 3) % 2 == 1);
      e.base    = (c % 4 == 0);
      sb.push_back(e);
      @(posedge clk); #1;
      got = {tick, sq, base_tick};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL pause c=%0d got tick=%b sq=%b base=%b exp tick=%b sq=%b base=%b",
                 c, got.tick, got.sq, got.base, e.tick, e.sq, e.base);
      end
    end
    pause = '0;
  endtask

  task automatic test_clr_paused();
    exp_t e, got;
    int a;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      pause = {1'b0, (c >= 9 && c <= 11)};
      clr   = {1'b0, (c == 10)};
      if (c <= 8) begin
        e.tick[0] = (c % 5 == 0);
        e.sq[0]   = ((c / 5) % 2 == 1);
      end else if (c <= 11) begin
        e.tick[0] = 1'b0;
        e.sq[0]   = (c == 9);
      end else begin
        a = c - 11;
        e.tick[0] = (a % 5 == 0);
        e.sq[0]   = ((a / 5) % 2 == 1);
      end
      e.tick[1] = (c % 3 == 0);
      e.sq[1]   = ((c / 3) % 2 == 1);
      e.base    = (c % 4 == 0);
      sb.push_back(e);
      @(posedge clk); #1;
      got = {tick, sq, base_tick};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL clr_paused c=%0d got tick=%b sq=%b base=%b exp tick=%b sq=%b base=%b",
                 c, got.tick, got.sq, got.base, e.tick, e.sq, e.base);
      end
    end
    pause = '0; clr = '0;
  endtask

  task automatic test_cfg_div();
    exp_t e, got;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      cfg_wr  = (c == 3 || c == 9);
      cfg_ch  = 1'b0;
      cfg_div = (c == 3) ? 8'd1 : 8'd0;
      if (c <= 2) begin
        e.tick[0] = 1'b0;
        e.sq[0]   = 1'b0;
      end else if (c == 3) begin
        e.tick[0] = 1'b0;
        e.sq[0]   = 1'b0;
      end else if (c <= 8) begin
        e.tick[0] = 1'b1;
        e.sq[0]   = ((c - 3) % 2 == 1);
      end else begin
        e.tick[0] = 1'b0;
        e.sq[0]   = 1'b1;
      end
      e.tick[1] = (c % 3 == 0);
      e.sq[1]   = ((c / 3) % 2 == 1);
      e.base    = (c % 4 == 0);
      sb.push_back(e);
      @(posedge clk); #1;
      got = {tick, sq, base_tick};
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cfg_div c=%0d got tick=%b sq=%b base=%b exp tick=%b sq=%b base=%b",
                 c, got.tick, got.sq, got.base, e.tick, e.sq, e.base);
      end
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_cfg_priority();
    exp_t  e, got;
    exp3_t e3, got3;
    int    a;
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      cfg_wr   = (c == 4);
      cfg_ch   = 1'b1;
      cfg_div  = 8'd4;
      clr      = {(c == 4), 1'b0};
      cfg_wr2  = (c == 2);
      cfg_ch2  = 2'd3;
      cfg_div2 = 8'd1;
      e.tick[0] = (c % 5 == 0);
      e.sq[0]   = ((c / 5) % 2 == 1);
      if (c <= 3) begin
        e.tick[1] = (c % 3 == 0);
        e.sq[1]   = ((c / 3) % 2 == 1);
      end else begin
        a = c - 4;
        e.tick[1] = (a > 0) && (a % 4 == 0);
        e.sq[1]   = ((a / 4) % 2 == 0);
      end
      e.base = (c % 4 == 0);
      e3.tick = {(c % 4 == 0), (c % 3 == 0), (c % 5 == 0)};
      e3.sq   = {((c / 4) % 2 == 1), ((c / 3) % 2 == 1), ((c / 5) % 2 == 1)};
      e3.base = (c % 4 == 0);
      sb.push_back(e);
      sb3.push_back(e3);
      @(posedge clk); #1;
      got  = {tick, sq, base_tick};
      got3 = {tick2, sq2, base_tick2};
      e  = sb.pop_front();
      e3 = sb3.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cfg_over_clr c=%0d got tick=%b sq=%b exp tick=%b sq=%b",
                 c, got.tick, got.sq, e.tick, e.sq);
      end
      n_cmp++;
      if (got3 !== e3) begin
        n_bad++;
        $display("FAIL cfg_out_of_range c=%0d got tick=%b sq=%b base=%b exp tick=%b sq=%b base=%b",
                 c, got3.tick, got3.sq, got3.base, e3.tick, e3.sq, e3.base);
      end
    end
    cfg_wr = 1'b0; cfg_wr2 = 1'b0; clr = '0;
  endtask

  task automatic test_mid_reset();
    exp_t e, got;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      cfg_wr  = (c == 1 || c == 2);
      cfg_ch  = (c == 2);
      cfg_div = (c == 1) ? 8'd2 : 8'd7;
      rst     = (c != 7);
      if (c == 7) sb.push_back('0);
      @(posedge clk); #1;
    end
    cfg_wr = 1'b0;
    got = {tick, sq, base_tick};
    e = sb.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL mid_reset got=%b exp=%b", got, e);
    end
    rst = 1'b1;
    test_free_run("after_mid_reset");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run("free_run");
    test_pause();
    test_clr_paused();
    test_cfg_div();
    test_cfg_priority();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
